// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: opcodes, FSM states
// and the helper that says which opcodes stall the pipeline.
package muldiv_pkg;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    function automatic logic is_multicycle(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the
// divisor from the remainder and shift the resulting quotient bit in.
module div_restoring_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] remQuo,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH:0]   nextRemQuo
);

    logic [WIDTH:0] remPart;
    logic [WIDTH:0] diff;
    logic           ge;

    // Remainder after the shift picks up the quotient MSB; it stays below 2*divisor.
    assign remPart    = remQuo[2*WIDTH-1:WIDTH-1];
    assign ge         = (remPart >= {1'b0, divisor});
    assign diff       = remPart - {1'b0, divisor};
    assign nextRemQuo = {(ge ? diff : remPart), remQuo[WIDTH-2:0], ge};

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair; stalls EX through
// busy_o until the result is committed, with flush/abort support.
module hilo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_ITER = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state, stateNext;
    logic [CW-1:0]    cnt;
    logic [2*WIDTH:0] acc;
    logic [WIDTH-1:0] absB;
    logic             negRes, negRem, opIsDiv, divZero;
    logic [WIDTH-1:0] hiReg, loReg;

    function automatic logic [WIDTH-1:0] negW(input logic [WIDTH-1:0] x);
        return -x;
    endfunction

    function automatic logic [2*WIDTH-1:0] negW2(input logic [2*WIDTH-1:0] x);
        return -x;
    endfunction

    // Operand decode for the launching cycle
    logic signed [WIDTH-1:0] aSgn, bSgn;
    logic                    signedOp, signA, signB, isMulIn, isDivIn, launch;
    logic [WIDTH-1:0]        absAIn, absBIn;
    logic [2*WIDTH-1:0]      prodFull;

    assign aSgn     = a_i;
    assign bSgn     = b_i;
    assign signedOp = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign signA    = signedOp && (aSgn < 0);
    assign signB    = signedOp && (bSgn < 0);
    assign absAIn   = signA ? negW(a_i) : a_i;
    assign absBIn   = signB ? negW(b_i) : b_i;
    assign isMulIn  = (op_i == OP_MULT) || (op_i == OP_MULTU);
    assign isDivIn  = (op_i == OP_DIV) || (op_i == OP_DIVU);
    assign launch   = start_i && !flush_i && is_multicycle(op_i);
    assign prodFull = {{WIDTH{1'b0}}, absAIn} * {{WIDTH{1'b0}}, absBIn};

    // Iteration datapaths: acc low half holds |a|, absB is divisor or multiplicand
    logic [2*WIDTH:0] divNext, mulNext;
    logic [WIDTH:0]   mulSum;

    div_restoring_step #(.WIDTH(WIDTH)) uStep (
        .remQuo    (acc[2*WIDTH-1:0]),
        .divisor   (absB),
        .nextRemQuo(divNext)
    );

    assign mulSum  = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, absB} : {(WIDTH+1){1'b0}});
    assign mulNext = {1'b0, mulSum, acc[WIDTH-1:1]};

    // Sign correction applied in FIX
    logic [2*WIDTH-1:0] mulRes;
    logic [WIDTH-1:0]   quoFix, remFix, hiFix, loFix;

    assign mulRes = negRes ? negW2(acc[2*WIDTH-1:0]) : acc[2*WIDTH-1:0];
    assign quoFix = negRes ? negW(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    assign remFix = negRem ? negW(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];

    always_comb begin
        hiFix = mulRes[2*WIDTH-1:WIDTH];
        loFix = mulRes[WIDTH-1:0];
        if (opIsDiv && divZero) begin
            hiFix = acc[WIDTH-1:0];
            loFix = '1;
        end else if (opIsDiv) begin
            hiFix = remFix;
            loFix = quoFix;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state)
            S_IDLE: begin
                if (launch) begin
                    busy_o = 1'b1;
                    if (isMulIn)
                        stateNext = (MUL_ITER != 0) ? S_MUL : S_FIX;
                    else
                        stateNext = (b_i == '0) ? S_FIX : S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                busy_o = 1'b1;
                if (flush_i)                     stateNext = S_IDLE;
                else if (cnt == CW'(WIDTH - 1))  stateNext = S_FIX;
            end
            S_FIX: begin
                busy_o    = 1'b1;
                stateNext = flush_i ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                done_o    = !flush_i;
                stateNext = S_IDLE;
            end
            default: stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= '0;
            absB    <= '0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            opIsDiv <= 1'b0;
            divZero <= 1'b0;
            hiReg   <= '0;
            loReg   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i && !flush_i && op_i == OP_MTHI) hiReg <= a_i;
                    if (start_i && !flush_i && op_i == OP_MTLO) loReg <= a_i;
                    if (launch) begin
                        cnt     <= '0;
                        absB    <= absBIn;
                        negRes  <= signA ^ signB;
                        negRem  <= signA;
                        opIsDiv <= isDivIn;
                        divZero <= isDivIn && (b_i == '0);
                        // Divide-by-zero keeps the raw dividend for HI
                        if (isMulIn && MUL_ITER == 0)
                            acc <= {1'b0, prodFull};
                        else if (isDivIn && b_i == '0)
                            acc <= {{(WIDTH+1){1'b0}}, a_i};
                        else
                            acc <= {{(WIDTH+1){1'b0}}, absAIn};
                    end
                end
                S_MUL: begin
                    acc <= mulNext;
                    cnt <= cnt + 1'b1;
                end
                S_DIV: begin
                    acc <= divNext;
                    cnt <= cnt + 1'b1;
                end
                S_FIX: begin
                    if (!flush_i) begin
                        hiReg <= hiFix;
                        loReg <= loFix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi_o = hiReg;
    assign lo_o = loReg;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench: one single-cycle-multiply and one iterative-multiply instance
// share stimulus; results and done_o latencies are checked against hand values.
module tb_hilo_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy0, done0, busy1, done1;
    logic [31:0] hi0, lo0, hi1, lo1;

    hilo_muldiv_unit #(.WIDTH(32), .MUL_ITER(0)) dut0 (
        .clk(clk), .rst(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .flush_i(flush), .busy_o(busy0), .done_o(done0), .hi_o(hi0), .lo_o(lo0)
    );

    hilo_muldiv_unit #(.WIDTH(32), .MUL_ITER(1)) dut1 (
        .clk(clk), .rst(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .flush_i(flush), .busy_o(busy1), .done_o(done1), .hi_o(hi1), .lo_o(lo1)
    );

    always #5 clk = ~clk;

    int   nCompared = 0;
    int   nMismatched = 0;
    int   doneCyc0, doneCyc1, doneCnt0, doneCnt1;
    logic busyC0, busyC1, busyAt0, busyAt1;
    logic [31:0] hiAt, loAt;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; that next cycle is cycle 0.
    task automatic runOp(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input int flushAt, input int rstAt, input bit hold);
        doneCyc0 = -1; doneCyc1 = -1; doneCnt0 = 0; doneCnt1 = 0;
        busyAt0 = 1'bx; busyAt1 = 1'bx; hiAt = 'x; loAt = 'x;
        start = 1'b1; op = o; a = av; b = bv;
        @(negedge clk);
        busyC0 = busy0; busyC1 = busy1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            flush = (c == flushAt);
            rst   = (c == rstAt);
            @(negedge clk);
            if (c == flushAt + 1 || c == rstAt) begin
                busyAt0 = busy0; busyAt1 = busy1; hiAt = hi0; loAt = lo0;
            end
            if (done0) begin doneCnt0++; if (doneCyc0 < 0) doneCyc0 = c; end
            if (done1) begin doneCnt1++; if (doneCyc1 < 0) doneCyc1 = c; end
            @(posedge clk); #1;
            if (hold && doneCnt0 > 0) start = 1'b0;
        end
        flush = 1'b0; rst = 1'b0; start = 1'b0;
    endtask

    task automatic moveTo(input logic [2:0] o, input logic [31:0] v);
        start = 1'b1; op = o; a = v; b = '0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = OP_NOP; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        checkVal("rst_hilo", {hi0, lo0}, 64'h0);
        checkVal("rst_busy_done", {62'h0, busy0, done0}, 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        runOp(OP_MULT, 32'hFFFFFFFE, 32'd3, -1, -1, 1'b0);
        checkVal("mult_busy_c0", {62'h0, busyC0, busyC1}, 64'h3);
        checkVal("mult_hilo0", {hi0, lo0}, 64'hFFFFFFFF_FFFFFFFA);
        checkVal("mult_hilo1", {hi1, lo1}, 64'hFFFFFFFF_FFFFFFFA);
        checkVal("mult_lat0", 64'(doneCyc0), 64'd2);
        checkVal("mult_lat1", 64'(doneCyc1), 64'd34);
        checkVal("mult_donecnt", 64'(doneCnt0 + doneCnt1), 64'd2);

        runOp(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1, 1'b0);
        checkVal("multu_hilo0", {hi0, lo0}, 64'hFFFFFFFE_00000001);
        checkVal("multu_hilo1", {hi1, lo1}, 64'hFFFFFFFE_00000001);

        runOp(OP_DIV, 32'hFFFFFFF9, 32'd2, -1, -1, 1'b0);
        checkVal("div_neg_hilo", {hi0, lo0}, 64'hFFFFFFFF_FFFFFFFD);
        checkVal("div_neg_lat", 64'(doneCyc0), 64'd34);

        runOp(OP_DIVU, 32'd7, 32'd2, -1, -1, 1'b0);
        checkVal("divu_7_2", {hi0, lo0}, 64'h00000001_00000003);

        runOp(OP_DIV, 32'h80000000, 32'hFFFFFFFF, -1, -1, 1'b0);
        checkVal("div_ovf", {hi0, lo0}, 64'h00000000_80000000);

        runOp(OP_DIVU, 32'd5, 32'd0, -1, -1, 1'b0);
        checkVal("divu_zero", {hi0, lo0}, 64'h00000005_FFFFFFFF);
        checkVal("divu_zero_lat", 64'(doneCyc0), 64'd2);

        runOp(OP_DIV, 32'hFFFFFFF8, 32'd0, -1, -1, 1'b0);
        checkVal("div_zero_raw", {hi0, lo0}, 64'hFFFFFFF8_FFFFFFFF);

        // Back-to-back MTHI/MTLO never stall
        start = 1'b1; op = OP_MTHI; a = 32'h0000ABCD;
        @(negedge clk);
        checkVal("mthi_busy", {63'h0, busy0}, 64'h0);
        @(posedge clk); #1;
        op = OP_MTLO; a = 32'h00001234;
        @(negedge clk);
        checkVal("mtlo_busy", {63'h0, busy0}, 64'h0);
        checkVal("mthi_hi", {32'h0, hi0}, 64'h0000ABCD);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checkVal("mtlo_hilo", {hi0, lo0}, 64'h0000ABCD_00001234);
        @(posedge clk); #1;

        moveTo(OP_MTHI, 32'h11);
        moveTo(OP_MTLO, 32'h22);
        runOp(OP_DIV, 32'd100, 32'd7, 20, -1, 1'b0);
        checkVal("flush_busy", {62'h0, busyAt0, busyAt1}, 64'h0);
        checkVal("flush_nodone", 64'(doneCnt0 + doneCnt1), 64'd0);
        checkVal("flush_hilo", {hi0, lo0}, 64'h00000011_00000022);

        runOp(OP_DIVU, 32'd100, 32'd7, -1, -1, 1'b1);
        checkVal("hold_donecnt", 64'(doneCnt0), 64'd1);
        checkVal("hold_lat", 64'(doneCyc0), 64'd34);
        checkVal("hold_hilo", {hi0, lo0}, 64'h00000002_0000000E);
        checkVal("hold_idle", {63'h0, busy0}, 64'h0);

        runOp(OP_DIV, 32'hFFFFFFF9, 32'd2, -1, 10, 1'b0);
        checkVal("rst_mid_hilo", {hiAt, loAt}, 64'h0);
        checkVal("rst_mid_busy", {62'h0, busyAt0, busyAt1}, 64'h0);
        checkVal("rst_mid_nodone", 64'(doneCnt0 + doneCnt1), 64'd0);
        checkVal("rst_mid_final", {hi0, lo0}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
